// File: rtl/i2c_master_arbiter_pkg.sv
// Shared encodings for the I2C master and its request arbiter, so both sides
// agree on state codes and completion status.
package i2c_master_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned ADDR_LEN_DEF = 7;
    localparam int unsigned DATA_LEN_DEF = 8;
    localparam int unsigned TIMEOUT_DEF  = 1023;

    typedef enum logic [2:0] {
        M_IDLE     = 3'd0,
        M_START    = 3'd1,
        M_ADDR     = 3'd2,
        M_ADDR_ACK = 3'd3,
        M_DATA     = 3'd4,
        M_DATA_ACK = 3'd5,
        M_STOP     = 3'd6
    } m_state_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10,
        ARB_RESP  = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_NACK    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Request-side and master-command-side signals of the arbiter in one bundle.
interface i2c_master_arbiter_if
    import i2c_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
    parameter int unsigned DATA_LEN = DATA_LEN_DEF
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
    logic [NUM_REQ-1:0]          req_rw;
    logic [NUM_REQ*DATA_LEN-1:0] req_wdata;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          done;
    logic [DATA_LEN-1:0]         rdata;
    logic [1:0]                  err;
    logic                        m_start;
    logic [ADDR_LEN-1:0]         m_addr;
    logic                        m_rw;
    logic [DATA_LEN-1:0]         m_wdata;
    logic                        m_abort;
    logic                        m_busy;
    logic                        m_done;
    logic [DATA_LEN-1:0]         m_rdata;
    logic                        m_nack;

    // Arbiter view
    modport slave (
        input  req, req_addr, req_rw, req_wdata, m_busy, m_done, m_rdata, m_nack,
        output gnt, done, rdata, err, m_start, m_addr, m_rw, m_wdata, m_abort
    );

    // Environment view: requesters plus the I2C master
    modport master (
        output req, req_addr, req_rw, req_wdata, m_busy, m_done, m_rdata, m_nack,
        input  gnt, done, rdata, err, m_start, m_addr, m_rw, m_wdata, m_abort
    );
endinterface

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Round-robin winner select: first set request strictly after ptr, wrapping.
module rr_pick
    import i2c_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_oh_c_o,
    output logic [IDX_W-1:0]   win_idx_c_o
);
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found       = 1'b0;
        cand        = '0;
        win_oh_c_o  = '0;
        win_idx_c_o = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found            = 1'b1;
                win_oh_c_o[cand] = 1'b1;
                win_idx_c_o      = cand;
            end
        end
    end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master among NUM_REQ requesters: round-robin grant, command
// latch, start/busy handshake and completion supervision with timeout abort.
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input logic            clk,
    input logic            rst_n,
    i2c_master_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    win_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [DATA_LEN-1:0] rdata_q;
    err_e                err_q;
    logic                m_start_q;
    logic                m_abort_q;
    logic [ADDR_LEN-1:0] m_addr_q;
    logic                m_rw_q;
    logic [DATA_LEN-1:0] m_wdata_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                cnt_last;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i       (bus.req),
        .ptr_i       (ptr_q),
        .win_oh_c_o  (pick_oh),
        .win_idx_c_o (pick_idx)
    );

    // Counter is about to reach TIMEOUT on this edge
    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            win_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= ERR_OK;
            m_start_q <= 1'b0;
            m_abort_q <= 1'b0;
            m_addr_q  <= '0;
            m_rw_q    <= 1'b0;
            m_wdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            done_q    <= '0;
            m_abort_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    cnt_q <= '0;
                    if (|bus.req) begin
                        win_q     <= pick_idx;
                        gnt_q     <= pick_oh;
                        m_addr_q  <= bus.req_addr[32'(pick_idx) * ADDR_LEN +: ADDR_LEN];
                        m_rw_q    <= bus.req_rw[pick_idx];
                        m_wdata_q <= bus.req_wdata[32'(pick_idx) * DATA_LEN +: DATA_LEN];
                        m_start_q <= 1'b1;
                        state_q   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // m_done here is ignored; only busy or timeout moves on
                    if (bus.m_busy) begin
                        m_start_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ARB_WAIT;
                    end else if (cnt_last) begin
                        m_start_q     <= 1'b0;
                        m_abort_q     <= 1'b1;
                        err_q         <= ERR_TIMEOUT;
                        rdata_q       <= '0;
                        done_q[win_q] <= 1'b1;
                        cnt_q         <= cnt_q + CNT_W'(1);
                        state_q       <= ARB_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_WAIT: begin
                    // Completion takes priority over a coincident timeout
                    if (bus.m_done) begin
                        rdata_q       <= bus.m_rdata;
                        err_q         <= bus.m_nack ? ERR_NACK : ERR_OK;
                        done_q[win_q] <= 1'b1;
                        state_q       <= ARB_RESP;
                    end else if (cnt_last) begin
                        m_abort_q     <= 1'b1;
                        err_q         <= ERR_TIMEOUT;
                        rdata_q       <= '0;
                        done_q[win_q] <= 1'b1;
                        cnt_q         <= cnt_q + CNT_W'(1);
                        state_q       <= ARB_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    ptr_q   <= win_q;
                    gnt_q   <= '0;
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
    assign bus.m_start = m_start_q;
    assign bus.m_abort = m_abort_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_rw    = m_rw_q;
    assign bus.m_wdata = m_wdata_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; the bench plays the requesters and
// the I2C master.
module tb_i2c_master_arbiter;
    import i2c_master_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned AL = 7;
    localparam int unsigned DL = 8;
    localparam int unsigned TO = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   k;
    int   lat;

    always #5 clk = ~clk;

    i2c_master_arbiter_if #(.NUM_REQ(NR), .ADDR_LEN(AL), .DATA_LEN(DL)) bus ();

    i2c_master_arbiter #(.NUM_REQ(NR), .ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The master never reports done in the same cycle it first goes busy
    always @(posedge clk)
        if (rst_n) assert (!(bus.m_start && bus.m_busy && bus.m_done))
            else $error("FAIL issue_done_overlap");

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cmd(input int i, input logic [AL-1:0] a, input logic rw,
                           input logic [DL-1:0] d);
        bus.req_addr[i*AL +: AL]  = a;
        bus.req_rw[i]             = rw;
        bus.req_wdata[i*DL +: DL] = d;
    endtask

    task automatic wait_start(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!bus.m_start && l < 20);
    endtask

    // One full transaction; optionally scrambles requester inputs after grant
    task automatic run_txn(input string tag, input int exp_lat, input logic [NR-1:0] exp_gnt,
                           input logic [AL-1:0] exp_addr, input logic exp_rw,
                           input logic [DL-1:0] exp_wdata, input int wait_cyc,
                           input logic [DL-1:0] rd, input logic nack,
                           input logic [1:0] exp_err, input bit perturb);
        int l;
        wait_start(l);
        chk({tag, "_lat"},  32'(l),          32'(exp_lat));
        chk({tag, "_gnt"},  32'(bus.gnt),    32'(exp_gnt));
        chk({tag, "_addr"}, 32'(bus.m_addr), 32'(exp_addr));
        if (perturb) begin
            bus.req       = '0;
            bus.req_addr  = '1;
            bus.req_wdata = '1;
            bus.req_rw    = '1;
        end
        bus.m_busy = 1'b1;
        @(negedge clk);
        chk({tag, "_start_drop"}, 32'(bus.m_start), 32'd0);
        chk({tag, "_addr_hold"},  32'(bus.m_addr),  32'(exp_addr));
        chk({tag, "_rw"},         32'(bus.m_rw),    32'(exp_rw));
        chk({tag, "_wdata"},      32'(bus.m_wdata), 32'(exp_wdata));
        chk({tag, "_gnt_hold"},   32'(bus.gnt),     32'(exp_gnt));
        repeat (wait_cyc) @(negedge clk);
        bus.m_done  = 1'b1;
        bus.m_rdata = rd;
        bus.m_nack  = nack;
        bus.m_busy  = 1'b0;
        @(negedge clk);
        bus.m_done = 1'b0;
        bus.m_nack = 1'b0;
        chk({tag, "_done"},  32'(bus.done),    32'(exp_gnt));
        chk({tag, "_rdata"}, 32'(bus.rdata),   32'(rd));
        chk({tag, "_err"},   32'(bus.err),     32'(exp_err));
        chk({tag, "_abort"}, 32'(bus.m_abort), 32'd0);
    endtask

    initial begin
        bus.req = '0;  bus.req_addr = '0;  bus.req_rw = '0;  bus.req_wdata = '0;
        bus.m_busy = 1'b0;  bus.m_done = 1'b0;  bus.m_rdata = '0;  bus.m_nack = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_gnt",   32'(bus.gnt),     32'd0);
        chk("rst_done",  32'(bus.done),    32'd0);
        chk("rst_rdata", 32'(bus.rdata),   32'd0);
        chk("rst_err",   32'(bus.err),     32'd0);
        chk("rst_start", 32'(bus.m_start), 32'd0);
        chk("rst_abort", 32'(bus.m_abort), 32'd0);
        chk("rst_addr",  32'(bus.m_addr),  32'd0);
        chk("rst_rw",    32'(bus.m_rw),    32'd0);
        chk("rst_wdata", 32'(bus.m_wdata), 32'd0);

        // Fairness from reset: all four held, order 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_cmd(i, AL'(8'h10 + i), 1'b0, DL'(8'hC0 + i));
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++)
            run_txn($sformatf("rr%0d", i), (i == 0) ? 1 : 2, NR'(1) << (i % 4),
                    AL'(8'h10 + (i % 4)), 1'b0, DL'(8'hC0 + (i % 4)), 0,
                    DL'(8'h60 + i), 1'b0, ERR_OK, 1'b0);
        bus.req = '0;

        // Single write from requester 0
        idle(2);
        set_cmd(0, 7'h50, 1'b0, 8'hA5);
        bus.req = 4'b0001;
        run_txn("single", 1, 4'b0001, 7'h50, 1'b0, 8'hA5, 3, 8'h00, 1'b0, ERR_OK, 1'b0);
        bus.req = '0;

        // Read with NACK from requester 2
        idle(2);
        set_cmd(2, 7'h2A, 1'b1, 8'hC2);
        bus.req = 4'b0100;
        run_txn("nack", 1, 4'b0100, 7'h2A, 1'b1, 8'hC2, 1, 8'h3C, 1'b1, ERR_NACK, 1'b0);
        bus.req = '0;

        // m_done coinciding with the final count: completion wins, no abort
        idle(2);
        bus.req = 4'b0010;
        run_txn("edge", 1, 4'b0010, 7'h11, 1'b0, 8'hC1, TO - 1, 8'h99, 1'b0, ERR_OK, 1'b0);
        bus.req = '0;

        // Timeout: ptr=1, req 3 and 0 pending, 3 wins then times out
        idle(2);
        set_cmd(3, 7'h13, 1'b0, 8'hC3);
        bus.req = 4'b1001;
        wait_start(lat);
        chk("to_lat", 32'(lat),     32'd1);
        chk("to_gnt", 32'(bus.gnt), 32'(4'b1000));
        bus.m_busy = 1'b1;
        @(negedge clk);
        chk("to_start_drop", 32'(bus.m_start), 32'd0);
        k = 0;
        while (!bus.m_abort && k < 1100) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", 32'(k),         32'(TO));
        chk("to_err",    32'(bus.err),   32'(ERR_TIMEOUT));
        chk("to_done",   32'(bus.done),  32'(4'b1000));
        chk("to_rdata",  32'(bus.rdata), 32'd0);
        bus.m_busy = 1'b0;
        bus.req    = 4'b0001;
        @(negedge clk);
        chk("to_abort_pulse", 32'(bus.m_abort), 32'd0);
        chk("to_done_pulse",  32'(bus.done),    32'd0);
        run_txn("after_to", 1, 4'b0001, 7'h50, 1'b0, 8'hA5, 0, 8'h77, 1'b0, ERR_OK, 1'b0);
        bus.req = '0;

        // Command stability: inputs scrambled and req dropped after grant
        idle(2);
        set_cmd(2, 7'h2A, 1'b0, 8'h5E);
        bus.req = 4'b0100;
        run_txn("stab", 1, 4'b0100, 7'h2A, 1'b0, 8'h5E, 2, 8'h11, 1'b0, ERR_OK, 1'b1);
        bus.req = '0;

        // Reset mid-WAIT: ptr=2, requester 3 wins before reset, 0 after
        idle(2);
        bus.req_rw = '0;
        set_cmd(0, 7'h50, 1'b0, 8'hA5);
        set_cmd(3, 7'h33, 1'b0, 8'hD3);
        bus.req = 4'b1011;
        wait_start(lat);
        chk("rm_gnt_pre", 32'(bus.gnt), 32'(4'b1000));
        bus.m_busy = 1'b1;
        idle(3);
        #2 rst_n = 1'b0;
        bus.m_busy = 1'b0;
        #1;
        chk("rm_gnt",   32'(bus.gnt),     32'd0);
        chk("rm_start", 32'(bus.m_start), 32'd0);
        chk("rm_done",  32'(bus.done),    32'd0);
        chk("rm_abort", 32'(bus.m_abort), 32'd0);
        chk("rm_addr",  32'(bus.m_addr),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("rm_after", 1, 4'b0001, 7'h50, 1'b0, 8'hA5, 0, 8'h42, 1'b0, ERR_OK, 1'b0);
        bus.req = '0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
